// File: rtl/port_uart_tx.sv
// Serial monitor for the slug CPU output port: each new port_out value goes out as 8 uppercase
// hex digits plus a line terminator, 8N1. Define PORT_UART_CRLF_EN for a CR+LF terminator instead of LF.
module port_uart_tx #(
    parameter int CLK_HZ = 25_000_000,
    parameter int BAUD   = 115_200
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic [31:0] port_out,
    output logic        tx,
    output logic        busy
);

    localparam int DIV = CLK_HZ / BAUD;
    localparam int CW  = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(DIV - 1);

`ifdef PORT_UART_CRLF_EN
    localparam int NBYTES = 10;
`else
    localparam int NBYTES = 9;
`endif

    localparam logic [3:0] BYTE_LAST = 4'(NBYTES - 1);
    localparam logic [3:0] BIT_STOP  = 4'd9;
    localparam logic [3:0] BIT_LAST_DATA = 4'd8;

    generate
        if (DIV < 2) begin : g_div_check
            $error("port_uart_tx: CLK_HZ / BAUD must be at least 2");
        end
    endgenerate

    typedef enum logic {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } state_t;

    state_t         state_q;
    logic [31:0]    shadow_q;
    logic [31:0]    frame_q;
    logic [3:0]     byte_idx_q;
    logic [3:0]     bit_idx_q;
    logic [CW-1:0]  baud_q;
    logic           tx_q;
    logic           busy_q;

    logic [7:0]     byte_tbl [NBYTES];
    logic [7:0]     cur_byte;

    // ASCII image of the captured frame, most significant nibble first.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_nib
            logic [3:0] nib;
            assign nib = frame_q[4*(7-gi) +: 4];
            assign byte_tbl[gi] = (nib < 4'd10) ? (8'h30 + {4'h0, nib})
                                                : (8'h37 + {4'h0, nib});
        end
    endgenerate

`ifdef PORT_UART_CRLF_EN
    assign byte_tbl[8] = 8'h0D;
    assign byte_tbl[9] = 8'h0A;
`else
    assign byte_tbl[8] = 8'h0A;
`endif

    always_comb begin
        cur_byte = 8'h0A;
        for (int i = 0; i < NBYTES; i++) begin
            if (byte_idx_q == 4'(i)) begin
                cur_byte = byte_tbl[i];
            end
        end
    end

    // tx is registered; each bit boundary loads the level of the bit that follows.
    always_ff @(posedge pclk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            shadow_q   <= '0;
            frame_q    <= '0;
            byte_idx_q <= '0;
            bit_idx_q  <= '0;
            baud_q     <= '0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (port_out != shadow_q) begin
                        shadow_q   <= port_out;
                        frame_q    <= port_out;
                        byte_idx_q <= '0;
                        bit_idx_q  <= '0;
                        baud_q     <= '0;
                        tx_q       <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (baud_q != BAUD_LAST) begin
                        baud_q <= baud_q + 1'b1;
                    end else begin
                        baud_q <= '0;
                        if (bit_idx_q != BIT_STOP) begin
                            bit_idx_q <= bit_idx_q + 1'b1;
                            tx_q      <= (bit_idx_q == BIT_LAST_DATA) ? 1'b1
                                                                      : cur_byte[bit_idx_q[2:0]];
                        end else if (byte_idx_q != BYTE_LAST) begin
                            byte_idx_q <= byte_idx_q + 1'b1;
                            bit_idx_q  <= '0;
                            tx_q       <= 1'b0;
                        end else begin
                            byte_idx_q <= '0;
                            bit_idx_q  <= '0;
                            tx_q       <= 1'b1;
                            busy_q     <= 1'b0;
                            state_q    <= S_IDLE;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign tx   = tx_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_port_uart_tx.sv
// Bench for port_uart_tx: a UART decoder feeds a scoreboard of expected bytes and busy lengths,
// with a vector table for single values and hand sequences for coalescing and mid-frame reset.
module tb_port_uart_tx;

    localparam int DIV = 10;
`ifdef PORT_UART_CRLF_EN
    localparam int N_BYTES = 10;
`else
    localparam int N_BYTES = 9;
`endif
    localparam int FRAME_CYC = 10 * DIV * N_BYTES;

    logic        pclk;
    logic        rst;
    logic [31:0] port_out;
    logic        tx;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    logic [7:0] exp_q[$];
    int         exp_busy_q[$];

    port_uart_tx #(
        .CLK_HZ(1_000_000),
        .BAUD  (100_000)
    ) dut (
        .pclk    (pclk),
        .rst     (rst),
        .port_out(port_out),
        .tx      (tx),
        .busy    (busy)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic push_bytes(input string s);
        for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
    endtask

    task automatic push_frame(input string hex);
        push_bytes(hex);
`ifdef PORT_UART_CRLF_EN
        exp_q.push_back(8'h0D);
`endif
        exp_q.push_back(8'h0A);
        exp_busy_q.push_back(FRAME_CYC);
    endtask

    // Decoder and busy-length monitor, sampling 1 time unit after each rising edge.
    initial begin : monitor
        int         rx_cnt;
        int         busy_run;
        logic [9:0] rx_bits;
        logic       rx_stable;
        logic [7:0] exp_b;
        int         exp_len;
        rx_cnt    = -1;
        busy_run  = 0;
        rx_bits   = '0;
        rx_stable = 1'b1;
        forever begin
            @(posedge pclk);
            #1;
            if (rst === 1'b1) begin
                rx_cnt   = -1;
                busy_run = 0;
            end else begin
                if (busy === 1'b1) begin
                    busy_run++;
                end else if (busy_run > 0) begin
                    if (exp_busy_q.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL busy_len: got %0d cycles, none expected", busy_run);
                    end else begin
                        exp_len = exp_busy_q.pop_front();
                        check("busy_len", busy_run, exp_len);
                    end
                    busy_run = 0;
                end
                if (rx_cnt < 0 && tx === 1'b0) begin
                    rx_cnt    = 0;
                    rx_stable = 1'b1;
                end
                if (rx_cnt >= 0) begin
                    if (rx_cnt % DIV == 0) rx_bits[rx_cnt / DIV] = tx;
                    else if (tx !== rx_bits[rx_cnt / DIV]) rx_stable = 1'b0;
                    if (rx_cnt == 10 * DIV - 1) begin
                        check("rx_framing", {29'd0, rx_stable, rx_bits[0], rx_bits[9]}, 32'b101);
                        if (exp_q.size() == 0) begin
                            checks++; failures++;
                            $display("FAIL rx_byte: got %0h, no byte expected", rx_bits[8:1]);
                        end else begin
                            exp_b = exp_q.pop_front();
                            check("rx_byte", rx_bits[8:1], exp_b);
                        end
                        rx_cnt = -1;
                    end else begin
                        rx_cnt++;
                    end
                end
            end
        end
    end

    task automatic wait_done(input string name, input int budget);
        int n;
        n = 0;
        do begin
            @(posedge pclk);
            #2;
            n++;
        end while ((busy !== 1'b0 || exp_q.size() != 0) && n < budget);
        check({name, "_done_pending"}, exp_q.size(), 0);
        check({name, "_done_busy"}, busy, 1'b0);
        check({name, "_busy_pending"}, exp_busy_q.size(), 0);
    endtask

    task automatic count_idle(input string name, input int cycles);
        int bad;
        bad = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge pclk);
            #1;
            if (tx !== 1'b1 || busy !== 1'b0) bad++;
        end
        check(name, bad, 0);
    endtask

    task automatic capture_check(input string name);
        @(posedge pclk);
        #1;
        check({name, "_start_tx"}, tx, 1'b0);
        check({name, "_start_busy"}, busy, 1'b1);
    endtask

    typedef struct {
        logic [31:0] value;
        string       hex;
        bit          sends;
    } vec_t;

    vec_t vecs[6];

    initial begin : stim
        int n;
        vecs[0] = '{32'h0000000A, "0000000A", 1'b1};
        vecs[1] = '{32'h0123ABCD, "0123ABCD", 1'b1};
        vecs[2] = '{32'hFFFFFFFF, "FFFFFFFF", 1'b1};
        vecs[3] = '{32'hFFFFFFFF, "",         1'b0};
        vecs[4] = '{32'h90000009, "90000009", 1'b1};
        vecs[5] = '{32'h00000000, "00000000", 1'b1};

        rst      = 1'b1;
        port_out = 32'h0;
        repeat (3) @(negedge pclk);
        check("reset_tx", tx, 1'b1);
        check("reset_busy", busy, 1'b0);
        rst = 1'b0;

        // Nothing goes out while port_out stays at the reset shadow value.
        count_idle("idle_after_reset", 2000);

        // Coalescing: 1, 2, 3 written mid-frame; only 3 follows, right after the stop bit.
        @(negedge pclk);
        port_out = 32'hDEADBEEF;
        push_frame("DEADBEEF");
        capture_check("deadbeef");
        repeat (100) @(negedge pclk);
        port_out = 32'h1;
        repeat (100) @(negedge pclk);
        port_out = 32'h2;
        repeat (100) @(negedge pclk);
        port_out = 32'h3;
        push_frame("00000003");
        n = 0;
        do begin
            @(posedge pclk);
            #1;
            n++;
        end while (busy !== 1'b0 && n < 2 * FRAME_CYC);
        check("first_frame_end", busy, 1'b0);
        capture_check("back_to_back");
        wait_done("coalesce", 2 * FRAME_CYC);
        count_idle("idle_after_coalesce", 300);

        // Reset during byte 3, bit 4 with port_out held.
        @(negedge pclk);
        port_out = 32'hDEADBEEF;
        push_bytes("DEA");
        capture_check("rst_frame");
        repeat (344) @(negedge pclk);
        rst = 1'b1;
        @(posedge pclk);
        #1;
        check("rst_edge_tx", tx, 1'b1);
        check("rst_edge_busy", busy, 1'b0);
        @(negedge pclk);
        rst = 1'b0;
        push_frame("DEADBEEF");
        capture_check("rst_restart");
        wait_done("rst_restart", 2 * FRAME_CYC);

        for (int i = 0; i < 6; i++) begin
            @(negedge pclk);
            port_out = vecs[i].value;
            if (vecs[i].sends) push_frame(vecs[i].hex);
            @(posedge pclk);
            #1;
            check("vec_busy", busy, vecs[i].sends);
            check("vec_tx", tx, !vecs[i].sends);
            if (vecs[i].sends) wait_done("vec", 2 * FRAME_CYC);
            else count_idle("vec_no_change", 200);
        end

        // A pulse away from and back to the sent value inside the frame is dropped.
        @(negedge pclk);
        port_out = 32'h5;
        push_frame("00000005");
        capture_check("pulse");
        repeat (150) @(negedge pclk);
        port_out = 32'h6;
        repeat (30) @(negedge pclk);
        port_out = 32'h5;
        wait_done("pulse", 2 * FRAME_CYC);
        count_idle("idle_after_pulse", 1500);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
